fpga: RTL and testbench
=======================

Name: fpga

Overview:
- 16-node serial bus transmitter with a round-robin arbiter.
- Each node n (1..16) presents a frame request: mode, receiver address, payload and a 4-bit CRC.
- The block grants one requesting node at a time, latches that node's fields, and serialises them MSB-first as one bit per clock on a single-wire bus output.
- It sits between the node register banks and the physical shared bus line.

Parameters:
- NODES, 16, number of requesting nodes; fixed, since ports are enumerated.
- ADDR_W, 4, width of the sender and receiver address fields.

Ports:
- clock  input  1  rising-edge system clock.
- reset_n  input  1  synchronous, active-low reset.
- CRC1..CRC16  input  4 each  CRC field to transmit for node n.
- Data1..Data16  input  64 each  payload for node n; only the low N bits are used (see mod).
- receiverAddr1..receiverAddr16  input  4 each  destination address for node n.
- mod1..mod16  input  2 each  node n request and length code:
  - 0 = no request.
  - 1 = 16-bit payload.
  - 2 = 32-bit payload.
  - 3 = 64-bit payload.
- bus_out  output  1  registered serial bus line; idles high.

Behaviour:
- Request: node n requests while modn != 0. The request is level-sensitive: a node holding modn != 0 is served again on each of its round-robin turns.
- Frame order, each field MSB first:
  1. SOF: 1 bit, '0'.
  2. SENDER: 4 bits, value n-1.
  3. RECEIVER: 4 bits.
  4. MOD: 2 bits.
  5. DATA: N bits = Data[N-1:0].
  6. CRC: 4 bits.
  7. EOF: 1 bit, '1'.
- Frame length is 16+N bits: 32, 48 or 80.
- States and transitions:
  - IDLE: bus_out=1. If any request exists, the arbiter scans from pointer p upward with wrap 16->1 and grants the first requester k. On that edge it latches CRCk, Datak, receiverAddrk and modk into a shift register and goes to SOF.
  - SOF: emits SOF, then goes to HDR.
  - HDR: emits SENDER, RECEIVER and MOD, then goes to DATA.
  - DATA: emits N bits, then goes to CRC.
  - CRC: emits 4 bits, then goes to EOF.
  - EOF: emits '1', then goes to IDLE.
- Pointer update: after granting k, p = k+1, wrapping 16->1.
- Latency: the first SOF bit appears on bus_out in the cycle after the grant edge.
- Inter-frame gap: minimum 2 high cycles (EOF plus one IDLE cycle).
- A continuously requesting single node repeats with a period of frame length + 1 (33 cycles for mod=1).
- Input changes while a frame is in progress have no effect; fields were latched at grant. A request dropped mid-frame does not abort the frame.
- Reset (reset_n=0 at a clock edge), including mid-frame:
  - state=IDLE, bus_out=1, p=1, shift register and counters cleared.
  - The frame in progress is abandoned.
- Bit counter is sized for 80 bits; no other arithmetic.
- Simultaneous requests: exactly one grant per arbitration, decided by round-robin order; no starvation. Each requester waits at most 15 frames.

Optional Feature:
- Macro CRC_GEN_EN.
- Defined: the CRC field is computed internally, ignoring CRCn.
  - Algorithm: CRC-4, polynomial x^4+x+1, initial value 0.
  - Covers SENDER, RECEIVER, MOD and DATA bits in transmit order.
  - Computed serially while those fields shift out, or precomputed at grant; either way, output timing is unchanged.
- Undefined: the latched CRCn value is transmitted verbatim.

Test Plan:
- Reset held low for 3 cycles with requests active -> bus_out=1 throughout; after release, the first SOF appears 2 cycles after the first non-reset edge.
- Node1 only, mod1=1, receiverAddr1=1, Data1=1, CRC1=1 (CRC_GEN_EN off):
  - bus_out = 0 0000 0001 01 0000000000000001 0001 1.
  - Then one idle '1', then the same 32-bit frame repeats every 33 cycles.
- Node3 with mod3=3, Data3=64'hA5A5_0000_0000_FFFF -> 80-bit frame with SENDER=0010, MOD=11, and all 64 data bits MSB-first.
- Nodes 2, 5 and 16 requesting with p=1 -> grant order 2, 5, 16, 2, ...; each frame carries its own sender ID.
- Data5 changed mid-frame, and reset_n pulsed low mid-frame of a second run:
  - The data change does not alter the frame in progress.
  - On reset, bus_out=1 on the next cycle and the next grant scans from node 1.
- CRC_GEN_EN defined, node1 frame as above -> CRC field equals the CRC-4 (x^4+x+1) of the 26 header and data bits, independent of the CRC1 input.

Source files
------------

// File: rtl/fpga.sv
// fpga: 16-node serial bus transmitter with round-robin arbitration.
// One requesting node is granted at a time. Its frame is latched at grant and
// sent MSB-first, one bit per clock, on bus_out:
//   SOF(0) | SENDER(4) | RECEIVER(4) | MOD(2) | DATA(16/32/64) | CRC(4) | EOF(1)
// Optional build macro CRC_GEN_EN: when defined, the CRC field is generated
// internally (CRC-4, x^4+x+1, init 0) over SENDER..DATA instead of using CRCn.
module fpga (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  CRC1,  CRC2,  CRC3,  CRC4,  CRC5,  CRC6,  CRC7,  CRC8,
                        CRC9,  CRC10, CRC11, CRC12, CRC13, CRC14, CRC15, CRC16,
    input  logic [63:0] Data1, Data2, Data3, Data4, Data5, Data6, Data7, Data8,
                        Data9, Data10, Data11, Data12, Data13, Data14, Data15, Data16,
    input  logic [3:0]  receiverAddr1,  receiverAddr2,  receiverAddr3,  receiverAddr4,
                        receiverAddr5,  receiverAddr6,  receiverAddr7,  receiverAddr8,
                        receiverAddr9,  receiverAddr10, receiverAddr11, receiverAddr12,
                        receiverAddr13, receiverAddr14, receiverAddr15, receiverAddr16,
    input  logic [1:0]  mod1,  mod2,  mod3,  mod4,  mod5,  mod6,  mod7,  mod8,
                        mod9,  mod10, mod11, mod12, mod13, mod14, mod15, mod16,
    output logic        bus_out
);

    localparam int NODES  = 16;
    localparam int ADDR_W = 4;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SOF  = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CRC  = 3'd4;
    localparam logic [2:0] S_EOF  = 3'd5;

    // Node n lives at index n-1, which is also the SENDER value on the wire.
    logic [NODES-1:0][3:0]        w_crc;
    logic [NODES-1:0][63:0]       w_data;
    logic [NODES-1:0][ADDR_W-1:0] w_rcv;
    logic [NODES-1:0][1:0]        w_mod;

    assign w_crc  = {CRC16, CRC15, CRC14, CRC13, CRC12, CRC11, CRC10, CRC9,
                     CRC8,  CRC7,  CRC6,  CRC5,  CRC4,  CRC3,  CRC2,  CRC1};
    assign w_data = {Data16, Data15, Data14, Data13, Data12, Data11, Data10, Data9,
                     Data8,  Data7,  Data6,  Data5,  Data4,  Data3,  Data2,  Data1};
    assign w_rcv  = {receiverAddr16, receiverAddr15, receiverAddr14, receiverAddr13,
                     receiverAddr12, receiverAddr11, receiverAddr10, receiverAddr9,
                     receiverAddr8,  receiverAddr7,  receiverAddr6,  receiverAddr5,
                     receiverAddr4,  receiverAddr3,  receiverAddr2,  receiverAddr1};
    assign w_mod  = {mod16, mod15, mod14, mod13, mod12, mod11, mod10, mod9,
                     mod8,  mod7,  mod6,  mod5,  mod4,  mod3,  mod2,  mod1};

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;     // index of the node that has first claim
    logic [74:0]       r_shift;   // SOF..DATA, payload left-aligned
    logic [3:0]        r_crc;
    logic [6:0]        r_cnt;     // bits still to send in the current field, minus one
    logic [1:0]        r_mod;

    logic              w_found;
    logic [ADDR_W-1:0] w_grant;
    logic [63:0]       w_data_al;
    logic [6:0]        w_data_last;

    // Round-robin scan: first requester at or after r_ptr, wrapping 15 -> 0.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_found = 1'b0;
        w_grant = r_ptr;
        for (int i = 0; i < NODES; i++) begin
            if (!w_found && (w_mod[r_ptr + ADDR_W'(i)] != 2'd0)) begin
                w_found = 1'b1;
                w_grant = r_ptr + ADDR_W'(i);
            end
        end
    end

    // Left-align the granted payload so its MSB directly follows the MOD field.
    always_comb begin
        case (w_mod[w_grant])
            2'd1:    w_data_al = {w_data[w_grant][15:0], 48'd0};
            2'd2:    w_data_al = {w_data[w_grant][31:0], 32'd0};
            default: w_data_al = w_data[w_grant];
        endcase
    end

    // Last index of the DATA field for the latched length code.
    always_comb begin
        case (r_mod)
            2'd2:    w_data_last = 7'd31;
            2'd3:    w_data_last = 7'd63;
            default: w_data_last = 7'd15;
        endcase
    end

`ifdef CRC_GEN_EN
    // One MSB-first step of CRC-4 with polynomial x^4+x+1.
    function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic b);
        logic fb;
        fb = b ^ c[3];
        return {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    endfunction
`endif

    // Frame sequencer: arbitrate in IDLE, then shift the latched frame out field by field.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            r_state <= S_IDLE;
            bus_out <= 1'b1;
            r_ptr   <= '0;
            r_shift <= '0;
            r_crc   <= '0;
            r_cnt   <= '0;
            r_mod   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    bus_out <= 1'b1;
                    if (w_found) begin
                        r_shift <= {1'b0, w_grant, w_rcv[w_grant], w_mod[w_grant], w_data_al};
                        r_mod   <= w_mod[w_grant];
`ifdef CRC_GEN_EN
                        r_crc   <= 4'd0;
`else
                        r_crc   <= w_crc[w_grant];
`endif
                        r_ptr   <= w_grant + ADDR_W'(1);
                        r_state <= S_SOF;
                    end
                end
                S_SOF: begin
                    bus_out <= r_shift[74];
                    r_shift <= {r_shift[73:0], 1'b0};
                    r_cnt   <= 7'd9;
                    r_state <= S_HDR;
                end
                S_HDR, S_DATA: begin
                    bus_out <= r_shift[74];
                    r_shift <= {r_shift[73:0], 1'b0};
`ifdef CRC_GEN_EN
                    r_crc   <= crc4_step(r_crc, r_shift[74]);
`endif
                    if (r_cnt != 7'd0) begin
                        r_cnt <= r_cnt - 7'd1;
                    end else if (r_state == S_HDR) begin
                        r_cnt   <= w_data_last;
                        r_state <= S_DATA;
                    end else begin
                        r_cnt   <= 7'd3;
                        r_state <= S_CRC;
                    end
                end
                S_CRC: begin
                    bus_out <= r_crc[3];
                    r_crc   <= {r_crc[2:0], 1'b0};
                    if (r_cnt != 7'd0) begin
                        r_cnt <= r_cnt - 7'd1;
                    end else begin
                        r_state <= S_EOF;
                    end
                end
                S_EOF: begin
                    bus_out <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    bus_out <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpga.sv
// tb_fpga: randomized/directed bench for the fpga serial bus transmitter.
// A frame-level reference model predicts every bus_out bit; compile with
// +define+CRC_GEN_EN to exercise the internal CRC generator.
module tb_fpga;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [15:0][3:0]  crc;
    logic [15:0][63:0] data;
    logic [15:0][3:0]  rcv;
    logic [15:0][1:0]  mods;
    logic              bus_out;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   exp_q[$];      // bits still expected for the frame in flight
    int   ptr = 0;       // model round-robin pointer (node index)
    logic exp_bit;
    logic seen_q[$];     // recorded bus_out samples

    always #5 clock = ~clock;

    fpga dut (
        .clock(clock), .reset_n(reset_n), .bus_out(bus_out),
        .CRC1(crc[0]), .CRC2(crc[1]), .CRC3(crc[2]), .CRC4(crc[3]),
        .CRC5(crc[4]), .CRC6(crc[5]), .CRC7(crc[6]), .CRC8(crc[7]),
        .CRC9(crc[8]), .CRC10(crc[9]), .CRC11(crc[10]), .CRC12(crc[11]),
        .CRC13(crc[12]), .CRC14(crc[13]), .CRC15(crc[14]), .CRC16(crc[15]),
        .Data1(data[0]), .Data2(data[1]), .Data3(data[2]), .Data4(data[3]),
        .Data5(data[4]), .Data6(data[5]), .Data7(data[6]), .Data8(data[7]),
        .Data9(data[8]), .Data10(data[9]), .Data11(data[10]), .Data12(data[11]),
        .Data13(data[12]), .Data14(data[13]), .Data15(data[14]), .Data16(data[15]),
        .receiverAddr1(rcv[0]), .receiverAddr2(rcv[1]), .receiverAddr3(rcv[2]),
        .receiverAddr4(rcv[3]), .receiverAddr5(rcv[4]), .receiverAddr6(rcv[5]),
        .receiverAddr7(rcv[6]), .receiverAddr8(rcv[7]), .receiverAddr9(rcv[8]),
        .receiverAddr10(rcv[9]), .receiverAddr11(rcv[10]), .receiverAddr12(rcv[11]),
        .receiverAddr13(rcv[12]), .receiverAddr14(rcv[13]), .receiverAddr15(rcv[14]),
        .receiverAddr16(rcv[15]),
        .mod1(mods[0]), .mod2(mods[1]), .mod3(mods[2]), .mod4(mods[3]),
        .mod5(mods[4]), .mod6(mods[5]), .mod7(mods[6]), .mod8(mods[7]),
        .mod9(mods[8]), .mod10(mods[9]), .mod11(mods[10]), .mod12(mods[11]),
        .mod13(mods[12]), .mod14(mods[13]), .mod15(mods[14]), .mod16(mods[15])
    );

`ifdef CRC_GEN_EN
    // CRC-4 as the remainder of msg(x)*x^4 divided by x^4+x+1 (long division).
    function automatic logic [3:0] ref_crc(input int msg[$]);
        int r[$];
        int poly[5] = '{1, 0, 0, 1, 1};
        int n;
        r = msg;
        repeat (4) r.push_back(0);
        n = msg.size();
        for (int i = 0; i < n; i++)
            if (r[i] != 0)
                for (int j = 0; j < 5; j++) r[i+j] = r[i+j] ^ poly[j];
        return {r[n] != 0, r[n+1] != 0, r[n+2] != 0, r[n+3] != 0};
    endfunction
`endif

    // Queue the complete frame of node index k as sampled right now.
    task automatic push_frame(input int k);
        int        msg[$];
        int        nbits;
        logic [3:0] kk;
        logic [3:0] cv;
        kk = 4'(k);
        nbits = (mods[k] == 2'd1) ? 16 : (mods[k] == 2'd2) ? 32 : 64;
        for (int b = 3; b >= 0; b--) msg.push_back(int'(kk[b]));
        for (int b = 3; b >= 0; b--) msg.push_back(int'(rcv[k][b]));
        for (int b = 1; b >= 0; b--) msg.push_back(int'(mods[k][b]));
        for (int b = nbits - 1; b >= 0; b--) msg.push_back(int'(data[k][b]));
`ifdef CRC_GEN_EN
        cv = ref_crc(msg);
`else
        cv = crc[k];
`endif
        exp_q.push_back(0);
        foreach (msg[i]) exp_q.push_back(msg[i]);
        for (int b = 3; b >= 0; b--) exp_q.push_back(int'(cv[b]));
        exp_q.push_back(1);
    endtask

    // Model reaction to one rising edge: expected bus_out after that edge.
    task automatic model_edge();
        if (!reset_n) begin
            exp_q.delete();
            ptr = 0;
            exp_bit = 1'b1;
        end else if (exp_q.size() == 0) begin
            exp_bit = 1'b1;
            for (int i = 0; i < 16; i++) begin
                if (mods[(ptr + i) % 16] != 2'd0) begin
                    push_frame((ptr + i) % 16);
                    ptr = (ptr + i + 1) % 16;
                    break;
                end
            end
        end else begin
            exp_bit = (exp_q.pop_front() != 0);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        cyc++;
        vectors++;
        assert (bus_out === exp_bit) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: bus_out=%b expected=%b", tag, cyc, bus_out, exp_bit);
        end
        seen_q.push_back(bus_out);
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) step(tag);
    endtask

    task automatic randomize_node(input int k, input logic [1:0] m);
        mods[k] = m;
        data[k] = {$urandom, $urandom};
        rcv[k]  = 4'($urandom);
        crc[k]  = 4'($urandom);
    endtask

    logic [31:0] k_frame1;
    int          bound;

    initial begin
        // Reset held for 3 cycles while random nodes request.
        reset_n = 1'b0;
        for (int k = 0; k < 16; k++) randomize_node(k, 2'($urandom));
        run(3, "reset_hold");

        // Node1 alone: known 32-bit frame, repeating every 33 cycles.
        mods = '0;
        mods[0] = 2'd1; rcv[0] = 4'd1; data[0] = 64'd1; crc[0] = 4'd1;
        reset_n = 1'b1;
        seen_q.delete();
        run(70, "node1");
        k_frame1 = 32'b0_0000_0001_01_0000000000000001_0001_1;
`ifdef CRC_GEN_EN
        begin
            int msg[$];
            logic [3:0] c;
            for (int b = 30; b >= 5; b--) msg.push_back(int'(k_frame1[b]));
            c = ref_crc(msg);
            k_frame1[4:1] = c;
        end
`endif
        vectors++;
        assert (seen_q[0] === 1'b1 && seen_q[33] === 1'b1) else begin
            miscompares++;
            $error("FAIL node1_idle: first=%b gap=%b expected=1/1", seen_q[0], seen_q[33]);
        end
        for (int i = 0; i < 32; i++) begin
            vectors++;
            assert (seen_q[1+i] === k_frame1[31-i] && seen_q[34+i] === k_frame1[31-i]) else begin
                miscompares++;
                $error("FAIL node1_const bit %0d: got=%b/%b expected=%b",
                       i, seen_q[1+i], seen_q[34+i], k_frame1[31-i]);
            end
        end

        // Node3 with a 64-bit payload (80-bit frames).
        mods = '0;
        randomize_node(2, 2'd3);
        data[2] = 64'hA5A5_0000_0000_FFFF;
        run(180, "node3_long");

        // Nodes 2, 5 and 16 in round robin starting from pointer 1.
        mods = '0;
        reset_n = 1'b0;
        run(2, "rr_reset");
        randomize_node(1, 2'($urandom_range(1, 3)));
        randomize_node(4, 2'($urandom_range(1, 3)));
        randomize_node(15, 2'($urandom_range(1, 3)));
        reset_n = 1'b1;
        run(400, "rr_2_5_16");

        // Node5 alone: change its data mid-frame, then reset mid-frame.
        mods = '0;
        run(90, "drain");
        randomize_node(4, 2'd3);
        bound = 0;
        while (!(exp_q.size() > 20 && exp_q.size() < 60) && bound < 200) begin
            step("wait_mid");
            bound++;
        end
        vectors++;
        assert (bound < 200) else begin
            miscompares++;
            $error("FAIL mid_frame_timeout: waited=%0d limit=%0d", bound, 200);
        end
        data[4] = {$urandom, $urandom};
        rcv[4]  = 4'($urandom);
        run(15, "data_change");
        reset_n = 1'b0;
        run(1, "mid_reset");
        reset_n = 1'b1;
        mods = '0;
        randomize_node(3, 2'd1);
        randomize_node(13, 2'd2);
        run(150, "post_reset_scan");

        // Random traffic with occasional resets.
        for (int it = 0; it < 25; it++) begin
            for (int k = 0; k < 16; k++)
                randomize_node(k, ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0);
            if ($urandom_range(0, 9) == 0) begin
                reset_n = 1'b0;
                run(1, "rand_reset");
                reset_n = 1'b1;
            end
            run($urandom_range(5, 90), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
